// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared state encoding, flag indices and MEM/WB control bundle for mem_stage
package mem_stage_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_NEG   = 1;
    localparam int FLAG_CARRY = 2;
    localparam int FLAG_OVF   = 3;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic branch;
        logic we;
    } ctrl_t;

endpackage

// File: rtl/mem_access_fsm.sv
// mem_access_fsm: IDLE/ACCESS sequencing of one data-memory access with a latched request.
// Optional abort counter is built only when MEM_STAGE_TIMEOUT_EN is defined.
module mem_access_fsm
    import mem_stage_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] target,
    input  logic [4:0]        wsel,
    input  logic              zero,
    input  ctrl_t             ctrl,
    input  logic              dmem_ack,
    output logic              busy,
    output logic              done,
    output logic              abort,
    output logic              stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic [DATA_W-1:0] lat_addr,
    output logic [DATA_W-1:0] lat_target,
    output logic [4:0]        lat_wsel,
    output logic              lat_zero,
    output ctrl_t             lat_ctrl
);

    state_t            state;
    logic [DATA_W-1:0] wdata_q;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

    assign busy       = (state == ACCESS);
    assign dmem_req   = busy;
    assign done       = busy & dmem_ack;
    assign stall      = (~busy & start) | (busy & ~dmem_ack & ~abort);
    assign dmem_we    = busy & lat_ctrl.we;
    assign dmem_addr  = {lat_addr[DATA_W-1:2], 2'b00};
    assign dmem_wdata = wdata_q;

`ifdef MEM_STAGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt;

    // ack on the limit cycle wins, so abort requires no ack
    assign abort = busy & ~dmem_ack & (cnt == CNT_W'(TIMEOUT - 1));

    // count ACCESS cycles; held at zero while IDLE so each access starts fresh
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt <= '0;
        else cnt <= busy ? cnt + 1'b1 : '0;
    end
`else
    assign abort = 1'b0;
`endif

    // state and request latch: capture on acceptance, hold until ack or abort
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            lat_addr   <= '0;
            lat_target <= '0;
            lat_wsel   <= '0;
            lat_zero   <= 1'b0;
            lat_ctrl   <= '0;
            wdata_q    <= '0;
        end else if (!busy) begin
            if (start) begin
                state      <= ACCESS;
                lat_addr   <= addr;
                lat_target <= target;
                lat_wsel   <= wsel;
                lat_zero   <= zero;
                lat_ctrl   <= ctrl;
                wdata_q    <= wdata;
            end
        end else if (dmem_ack || abort) begin
            state <= IDLE;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage with req/ack data memory, branch resolution and alignment fault.
// Define MEM_STAGE_TIMEOUT_EN to abort accesses that see no ack within TIMEOUT cycles.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] alu_in,
    input  logic [DATA_W-1:0] store_data,
    input  logic [4:0]        wsel_in,
    input  logic [3:0]        flags_in,
    input  logic [DATA_W-1:0] branch_in,
    input  logic              ctr_mem_read,
    input  logic              ctr_mem_write,
    input  logic              ctr_branch,
    input  logic              ctr_reg_write,
    input  logic              ctr_mem_to_reg,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic              stall,
    output logic              pc_src,
    output logic [DATA_W-1:0] branch_target,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic              wb_mem_to_reg,
    output logic [DATA_W-1:0] wb_mem_data,
    output logic [DATA_W-1:0] wb_alu,
    output logic [4:0]        wb_wsel,
    output logic              fault
);

    logic              mem_op;
    logic              misalign;
    logic              start;
    logic              busy;
    logic              done;
    logic              abort;
    ctrl_t             ctrl;
    ctrl_t             lat_ctrl;
    logic [DATA_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_target;
    logic [4:0]        lat_wsel;
    logic              lat_zero;
    logic              unused_flags;

    assign mem_op       = valid_in & (ctr_mem_read | ctr_mem_write);
    assign misalign     = |alu_in[1:0];
    assign start        = mem_op & ~misalign;
    assign unused_flags = ^flags_in[FLAG_OVF:FLAG_NEG];
    assign ctrl         = '{reg_write: ctr_reg_write, mem_to_reg: ctr_mem_to_reg,
                            branch: ctr_branch, we: ctr_mem_write};

    mem_access_fsm #(
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) u_fsm (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .addr      (alu_in),
        .wdata     (store_data),
        .target    (branch_in),
        .wsel      (wsel_in),
        .zero      (flags_in[FLAG_ZERO]),
        .ctrl      (ctrl),
        .dmem_ack  (dmem_ack),
        .busy      (busy),
        .done      (done),
        .abort     (abort),
        .stall     (stall),
        .dmem_req  (dmem_req),
        .dmem_we   (dmem_we),
        .dmem_addr (dmem_addr),
        .dmem_wdata(dmem_wdata),
        .lat_addr  (lat_addr),
        .lat_target(lat_target),
        .lat_wsel  (lat_wsel),
        .lat_zero  (lat_zero),
        .lat_ctrl  (lat_ctrl)
    );

    // writeback register set: access completion, direct IDLE retire (non-memory or misaligned), or bubble
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid      <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_mem_to_reg <= 1'b0;
            wb_mem_data   <= '0;
            wb_alu        <= '0;
            wb_wsel       <= '0;
            pc_src        <= 1'b0;
            branch_target <= '0;
            fault         <= 1'b0;
        end else if (done || abort) begin
            wb_valid      <= 1'b1;
            wb_reg_write  <= done & lat_ctrl.reg_write;
            wb_mem_to_reg <= done & lat_ctrl.mem_to_reg;
            wb_mem_data   <= (done & ~lat_ctrl.we) ? dmem_rdata : '0;
            wb_alu        <= lat_addr;
            wb_wsel       <= lat_wsel;
            pc_src        <= done & lat_ctrl.branch & lat_zero;
            branch_target <= lat_target;
            fault         <= abort;
        end else if (!busy && valid_in && !start) begin
            wb_valid      <= 1'b1;
            wb_reg_write  <= ~mem_op & ctr_reg_write;
            wb_mem_to_reg <= ~mem_op & ctr_mem_to_reg;
            wb_mem_data   <= '0;
            wb_alu        <= alu_in;
            wb_wsel       <= wsel_in;
            pc_src        <= ctr_branch & flags_in[FLAG_ZERO];
            branch_target <= branch_in;
            fault         <= mem_op;
        end else begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            pc_src       <= 1'b0;
            fault        <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed scoreboard bench for mem_stage
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic [31:0] alu_in;
    logic [31:0] store_data;
    logic [4:0]  wsel_in;
    logic [3:0]  flags_in;
    logic [31:0] branch_in;
    logic        ctr_mem_read;
    logic        ctr_mem_write;
    logic        ctr_branch;
    logic        ctr_reg_write;
    logic        ctr_mem_to_reg;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        stall;
    logic        pc_src;
    logic [31:0] branch_target;
    logic        wb_valid;
    logic        wb_reg_write;
    logic        wb_mem_to_reg;
    logic [31:0] wb_mem_data;
    logic [31:0] wb_alu;
    logic [4:0]  wb_wsel;
    logic        fault;

    typedef struct {
        logic [31:0] alu;
        logic [4:0]  wsel;
        logic        rw;
        logic        m2r;
        logic [31:0] data;
        logic        flt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk           (clk),
        .reset         (reset),
        .valid_in      (valid_in),
        .alu_in        (alu_in),
        .store_data    (store_data),
        .wsel_in       (wsel_in),
        .flags_in      (flags_in),
        .branch_in     (branch_in),
        .ctr_mem_read  (ctr_mem_read),
        .ctr_mem_write (ctr_mem_write),
        .ctr_branch    (ctr_branch),
        .ctr_reg_write (ctr_reg_write),
        .ctr_mem_to_reg(ctr_mem_to_reg),
        .dmem_rdata    (dmem_rdata),
        .dmem_ack      (dmem_ack),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .stall         (stall),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .wb_valid      (wb_valid),
        .wb_reg_write  (wb_reg_write),
        .wb_mem_to_reg (wb_mem_to_reg),
        .wb_mem_data   (wb_mem_data),
        .wb_alu        (wb_alu),
        .wb_wsel       (wb_wsel),
        .fault         (fault)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic rd, input logic wr, input logic br,
                         input logic rw, input logic m2r, input logic [31:0] alu,
                         input logic [31:0] sd, input logic [31:0] tgt,
                         input logic [4:0] ws, input logic [3:0] fl);
        valid_in       = v;
        ctr_mem_read   = rd;
        ctr_mem_write  = wr;
        ctr_branch     = br;
        ctr_reg_write  = rw;
        ctr_mem_to_reg = m2r;
        alu_in         = alu;
        store_data     = sd;
        branch_in      = tgt;
        wsel_in        = ws;
        flags_in       = fl;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0, 4'h0);
    endtask

    task automatic expect_wb(input logic [31:0] alu, input logic [4:0] ws, input logic rw,
                             input logic m2r, input logic [31:0] data, input logic flt);
        exp_t e;
        e.alu  = alu;
        e.wsel = ws;
        e.rw   = rw;
        e.m2r  = m2r;
        e.data = data;
        e.flt  = flt;
        sb.push_back(e);
    endtask

    // scoreboard: every retired writeback must match the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (!reset && wb_valid) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_wb", wb_valid, 1'b0);
            end else begin
                e = sb.pop_front();
                check("sb_alu", wb_alu, e.alu);
                check("sb_wsel", wb_wsel, e.wsel);
                check("sb_reg_write", wb_reg_write, e.rw);
                check("sb_mem_to_reg", wb_mem_to_reg, e.m2r);
                check("sb_mem_data", wb_mem_data, e.data);
                check("sb_fault", fault, e.flt);
            end
        end
    end

    initial begin
        int   stall_cnt;
        int   we_cnt;
        int   req_cnt;
        logic seen;
        reset      = 1'b1;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        idle();
        repeat (2) @(negedge clk);
        check("rst_req", dmem_req, 1'b0);
        check("rst_we", dmem_we, 1'b0);
        check("rst_addr", dmem_addr, 32'h0);
        check("rst_stall", stall, 1'b0);
        check("rst_pc_src", pc_src, 1'b0);
        check("rst_target", branch_target, 32'h0);
        check("rst_wb_valid", wb_valid, 1'b0);
        check("rst_wb_alu", wb_alu, 32'h0);
        check("rst_fault", fault, 1'b0);
        reset = 1'b0;

        @(negedge clk);
        drive(1, 0, 0, 0, 1, 0, 32'h10, 32'h0, 32'h0, 5'd7, 4'h0);
        expect_wb(32'h10, 5'd7, 1'b1, 1'b0, 32'h0, 1'b0);
        #1 check("nm_stall", stall, 1'b0);
        check("nm_req", dmem_req, 1'b0);
        @(negedge clk);
        idle();
        check("nm_wb_valid", wb_valid, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, i[0], 0, 32'h1000 + i * 4, 32'h0, 32'h0, 5'(i + 1), 4'h0);
            expect_wb(32'h1000 + i * 4, 5'(i + 1), i[0], 1'b0, 32'h0, 1'b0);
            #1 check("b2b_stall", stall, 1'b0);
            @(negedge clk);
        end
        idle();

        @(negedge clk);
        drive(1, 1, 0, 0, 1, 1, 32'h40, 32'h0, 32'h0, 5'd3, 4'h0);
        expect_wb(32'h40, 5'd3, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0);
        #1 stall_cnt = int'(stall);
        check("ld_req_accept", dmem_req, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 stall_cnt += int'(stall);
            check("ld_req", dmem_req, 1'b1);
            check("ld_addr", dmem_addr, 32'h40);
            check("ld_we", dmem_we, 1'b0);
        end
        @(negedge clk);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hDEADBEEF;
        #1 stall_cnt += int'(stall);
        check("ld_addr_ack", dmem_addr, 32'h40);
        check("ld_stall_cycles", stall_cnt, 4);
        @(negedge clk);
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        idle();
        #1 check("ld_req_drop", dmem_req, 1'b0);

        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0, 4'h0);
        drive(1, 0, 1, 0, 0, 0, 32'h80, 32'h12345678, 32'h0, 5'd0, 4'h0);
        expect_wb(32'h80, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0);
        #1 we_cnt = int'(dmem_we);
        check("st_stall_accept", stall, 1'b1);
        @(negedge clk);
        dmem_ack = 1'b1;
        #1 we_cnt += int'(dmem_we);
        check("st_wdata", dmem_wdata, 32'h12345678);
        check("st_addr", dmem_addr, 32'h80);
        check("st_stall_ack", stall, 1'b0);
        @(negedge clk);
        dmem_ack = 1'b0;
        idle();
        #1 we_cnt += int'(dmem_we);
        check("st_req_drop", dmem_req, 1'b0);
        @(negedge clk);
        #1 we_cnt += int'(dmem_we);
        check("st_we_cycles", we_cnt, 1);

        drive(1, 1, 0, 0, 1, 0, 32'h42, 32'h0, 32'h0, 5'd5, 4'h0);
        expect_wb(32'h42, 5'd5, 1'b0, 1'b0, 32'h0, 1'b1);
        #1 check("mis_req", dmem_req, 1'b0);
        check("mis_stall", stall, 1'b0);
        @(negedge clk);
        idle();
        #1 check("mis_fault", fault, 1'b1);
        check("mis_req_after", dmem_req, 1'b0);
        @(negedge clk);
        #1 check("mis_fault_pulse", fault, 1'b0);

        @(negedge clk);
        drive(1, 0, 0, 1, 0, 0, 32'h0, 32'h0, 32'h100, 5'd0, 4'b0001);
        expect_wb(32'h0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        drive(1, 0, 0, 1, 0, 0, 32'h0, 32'h0, 32'h200, 5'd0, 4'b0000);
        expect_wb(32'h0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0);
        #1 check("br_taken", pc_src, 1'b1);
        check("br_target", branch_target, 32'h100);
        @(negedge clk);
        idle();
        #1 check("br_not_taken", pc_src, 1'b0);
        check("br_target_nt", branch_target, 32'h200);

        @(negedge clk);
        dmem_ack = 1'b1;
        #1 check("idle_ack_req", dmem_req, 1'b0);
        check("idle_ack_stall", stall, 1'b0);
        @(negedge clk);
        dmem_ack = 1'b0;
        #1 check("idle_ack_wb", wb_valid, 1'b0);

`ifdef MEM_STAGE_TIMEOUT_EN
        @(negedge clk);
        drive(1, 1, 0, 0, 1, 1, 32'h44, 32'h0, 32'h0, 5'd9, 4'h0);
        expect_wb(32'h44, 5'd9, 1'b0, 1'b0, 32'h0, 1'b1);
        req_cnt = 0;
        seen    = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            #1 if (fault) seen = 1'b1;
            else req_cnt += int'(dmem_req);
        end
        idle();
        check("to_fault_seen", seen, 1'b1);
        check("to_cycles", req_cnt, 15);
        @(negedge clk);
        #1 check("to_fault_pulse", fault, 1'b0);
`else
        req_cnt = 0;
        seen    = 1'b0;
`endif

        @(negedge clk);
        check("sb_drained", sb.size(), 0);
        drive(1, 1, 0, 0, 1, 1, 32'h40, 32'h0, 32'h0, 5'd2, 4'h0);
        @(negedge clk);
        #1 check("rst_mid_req1", dmem_req, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        #1 check("rst_mid_req", dmem_req, 1'b0);
        idle();
        #1 check("rst_mid_stall", stall, 1'b0);
        check("rst_mid_wb_valid", wb_valid, 1'b0);
        check("rst_mid_target", branch_target, 32'h0);
        check("rst_mid_pc_src", pc_src, 1'b0);
        check("rst_mid_fault", fault, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hCAFEF00D;
        #1 check("late_ack_req", dmem_req, 1'b0);
        @(negedge clk);
        dmem_ack = 1'b0;
        #1 check("late_ack_wb_valid", wb_valid, 1'b0);
        check("late_ack_mem_data", wb_mem_data, 32'h0);
        @(negedge clk);
        check("sb_final", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
